// File: rtl/team_06_button_conditioner.sv
// Four-button front end: two-flop synchroniser, per-button debounce, press/release strobes.
// Long-press strobes are built only when TEAM_06_LONG_PRESS_EN is defined.
module team_06_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] long_press
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..65535");
  end
  if (LONG_CYCLES < 2 || LONG_CYCLES > 16777215) begin : g_bad_long
    $error("LONG_CYCLES must be in 2..2^24-1");
  end

  logic [3:0]  s1_q, s2_q;
  logic [3:0]  lvl_q, lvl_d;
  logic [3:0]  press_q, press_d;
  logic [3:0]  release_q, release_d;
  // NOTE: only four counters, so they are reset like ordinary flops rather than left as memory.
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];

  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path can infer a latch.
    lvl_d     = lvl_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        lvl_d[i]     = s2_q[i];
        cnt_d[i]     = '0;
        press_d[i]   = s2_q[i];
        release_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, as hardware does.
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level   = lvl_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef TEAM_06_LONG_PRESS_EN
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);

  logic [23:0] hcnt_q [4];
  logic [23:0] hcnt_d [4];
  logic [3:0]  fired_q, fired_d;
  logic [3:0]  long_q, long_d;

  // Hold counter stops at the terminal value; the fired flag allows one strobe per hold.
  always_comb begin
    fired_d = fired_q;
    long_d  = '0;
    for (int i = 0; i < 4; i++) begin
      hcnt_d[i] = hcnt_q[i];
      if (!lvl_q[i]) begin
        hcnt_d[i]  = '0;
        fired_d[i] = 1'b0;
      end else if (!fired_q[i]) begin
        if (hcnt_q[i] == LONG_LAST) begin
          long_d[i]  = 1'b1;
          fired_d[i] = 1'b1;
        end else begin
          hcnt_d[i] = hcnt_q[i] + 24'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fired_q <= '0;
      long_q  <= '0;
      for (int i = 0; i < 4; i++) hcnt_q[i] <= '0;
    end else begin
      fired_q <= fired_d;
      long_q  <= long_d;
      for (int i = 0; i < 4; i++) hcnt_q[i] <= hcnt_d[i];
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_team_06_button_conditioner.sv
// Bench for team_06_button_conditioner: directed vector table, hand-written corner sequences,
// and random stimulus compared every cycle against a sliding-window behavioural model.
module tb_team_06_button_conditioner;

  localparam int D = 4;
  localparam int L = 8;
`ifdef TEAM_06_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_press, btn_release, long_press;

  team_06_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: hist[j] is the raw input captured j edges ago. A level flips when the
  // samples 2..D+1 edges old (what the synchroniser has delivered) all disagree with it.
  logic [3:0] hist [0:D+1];
  logic [3:0] m_lvl, m_press, m_rel, m_long;
  int         age [4];

  task automatic model_reset();
    for (int j = 0; j <= D + 1; j++) hist[j] = '0;
    m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
    for (int i = 0; i < 4; i++) age[i] = 0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] b);
    logic flip;
    m_press = '0; m_rel = '0; m_long = '0;
    if (r) begin
      model_reset();
    end else begin
      for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = b;
      for (int i = 0; i < 4; i++) begin
        if (m_lvl[i]) begin
          age[i]++;
          if (LONG_EN && age[i] == L) m_long[i] = 1'b1;
        end
        flip = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (hist[j][i] == m_lvl[i]) flip = 1'b0;
        if (flip) begin
          m_lvl[i] = ~m_lvl[i];
          age[i]   = 0;
          if (m_lvl[i]) m_press[i] = 1'b1;
          else          m_rel[i]   = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, sample 1 ns later.
  task automatic tick(input logic r, input logic [3:0] b);
    rst    = r;
    btn_in = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check("model.level",   btn_level,   m_lvl);
    check("model.press",   btn_press,   m_press);
    check("model.release", btn_release, m_rel);
    check("model.long",    long_press,  m_long);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] press;
    logic [3:0] rel;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] b, input logic [3:0] lv,
                              input logic [3:0] p, input logic [3:0] rl);
    vec_t v;
    v.rst = r; v.btn = b; v.lvl = lv; v.press = p; v.rel = rl;
    return v;
  endfunction

  vec_t       vecs [24];
  logic [3:0] cur;
  logic       r_rand;

  initial begin
    // Reset held 2 cycles with all buttons pressed, then press strobe at E+5 (row 7).
    vecs[0]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[1]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[2]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[3]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[4]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[5]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[6]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[7]  = mk(1'b0, 4'hF, 4'hF, 4'hF, 4'h0);
    vecs[8]  = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h0);
    // Reset clears levels silently; clean press (E=10) and release (F=17) on bit 2.
    vecs[9]  = mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[10] = mk(1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[11] = mk(1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[12] = mk(1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[13] = mk(1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[14] = mk(1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[15] = mk(1'b0, 4'h4, 4'h4, 4'h4, 4'h0);
    vecs[16] = mk(1'b0, 4'h4, 4'h4, 4'h0, 4'h0);
    vecs[17] = mk(1'b0, 4'h0, 4'h4, 4'h0, 4'h0);
    vecs[18] = mk(1'b0, 4'h0, 4'h4, 4'h0, 4'h0);
    vecs[19] = mk(1'b0, 4'h0, 4'h4, 4'h0, 4'h0);
    vecs[20] = mk(1'b0, 4'h0, 4'h4, 4'h0, 4'h0);
    vecs[21] = mk(1'b0, 4'h0, 4'h4, 4'h0, 4'h0);
    vecs[22] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h4);
    vecs[23] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    model_reset();
    rst    = 1'b1;
    btn_in = 4'h0;

    for (int i = 0; i < 24; i++) begin
      tick(vecs[i].rst, vecs[i].btn);
      check($sformatf("vec%0d.level", i),   btn_level,   vecs[i].lvl);
      check($sformatf("vec%0d.press", i),   btn_press,   vecs[i].press);
      check($sformatf("vec%0d.release", i), btn_release, vecs[i].rel);
    end

    // 3-cycle glitch on bit 1 must leave level and strobes untouched.
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, (k < 3) ? 4'b0010 : 4'b0000);
      check("glitch3.bit1", {1'b0, btn_level[1], btn_press[1], btn_release[1]}, 4'b0000);
    end

    // 4-cycle pulse on bit 1: press at E+5, release four cycles later.
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, (k < 4) ? 4'b0010 : 4'b0000);
      check("pulse4.press1",   {3'b000, btn_press[1]},   {3'b000, k == 5});
      check("pulse4.release1", {3'b000, btn_release[1]}, {3'b000, k == 9});
    end

    // Bits 0 and 3 rise while bit 2 falls on the same capture edge.
    for (int k = 0; k < 7; k++) tick(1'b0, 4'b0100);
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 4'b1001);
      check("simul.press",   btn_press,   (k == 5) ? 4'b1001 : 4'b0000);
      check("simul.release", btn_release, (k == 5) ? 4'b0100 : 4'b0000);
    end

    // Reset arrives when the bit-3 count has reached 2; the count restarts afterwards.
    tick(1'b1, 4'b0000);
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0000);
    for (int k = 0; k < 4; k++) tick(1'b0, 4'b1000);
    tick(1'b1, 4'b1000);
    check("midrst.level", btn_level, 4'b0000);
    check("midrst.press", btn_press, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 4'b1000);
      check("midrst.press3",  {3'b000, btn_press[3]}, {3'b000, k == 5});
      check("midrst.release", btn_release, 4'b0000);
    end

    // Long hold on bit 0: one long strobe at P+L (P at k=5), release still fires.
    tick(1'b1, 4'b0000);
    for (int k = 0; k < 34; k++) begin
      tick(1'b0, (k < 26) ? 4'b0001 : 4'b0000);
      check("long.press0",   {3'b000, btn_press[0]},   {3'b000, k == 5});
      check("long.strobe",   long_press,               {3'b000, LONG_EN && (k == 5 + L)});
      check("long.release0", {3'b000, btn_release[0]}, {3'b000, k == 31});
    end

    // Random traffic: slow per-bit toggling mixes glitches and holds, rare resets.
    cur = 4'h0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(5) == 0) cur[i] = ~cur[i];
      r_rand = ($urandom_range(199) == 0);
      tick(r_rand, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
